// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file sequencer/arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rf_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Identity of the requester that owns the command in flight
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    // Distance in cnt_clk counts between the two access slots of a period
    localparam int SLOT_SPACING = 4;

    // One latched register-file command
    typedef struct packed {
        logic       wr;
        logic [3:0] raddr1;
        logic [3:0] raddr2;
        logic [3:0] waddr;
        logic [7:0] wdata;
    } cmd_t;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Bundle of both requester ports and the register-file access port.
// Latency: none (wiring only).
// Backpressure: req is held by a requester until its one-cycle ack pulse.
// Modports: master = requesters plus register file; slave = the arbiter.
interface reg_file_arbiter_if;

    // requester A (core execute unit)
    logic       a_req;
    logic       a_wr;
    logic [3:0] a_raddr1;
    logic [3:0] a_raddr2;
    logic [3:0] a_waddr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata1;
    logic [7:0] a_rdata2;

    // requester B (debug / context-save port)
    logic       b_req;
    logic       b_wr;
    logic [3:0] b_raddr1;
    logic [3:0] b_raddr2;
    logic [3:0] b_waddr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata1;
    logic [7:0] b_rdata2;

    // register file access port
    logic       rf_WR;
    logic [3:0] rf_Read_Addr1;
    logic [3:0] rf_Read_Addr2;
    logic [3:0] rf_Write_Addr;
    logic [7:0] rf_Write_Data;
    logic [7:0] rf_Dout1;
    logic [7:0] rf_Dout2;

    modport master (
        output a_req, a_wr, a_raddr1, a_raddr2, a_waddr, a_wdata,
        input  a_ack, a_rdata1, a_rdata2,
        output b_req, b_wr, b_raddr1, b_raddr2, b_waddr, b_wdata,
        input  b_ack, b_rdata1, b_rdata2,
        input  rf_WR, rf_Read_Addr1, rf_Read_Addr2, rf_Write_Addr, rf_Write_Data,
        output rf_Dout1, rf_Dout2
    );

    modport slave (
        input  a_req, a_wr, a_raddr1, a_raddr2, a_waddr, a_wdata,
        output a_ack, a_rdata1, a_rdata2,
        input  b_req, b_wr, b_raddr1, b_raddr2, b_waddr, b_wdata,
        output b_ack, b_rdata1, b_rdata2,
        output rf_WR, rf_Read_Addr1, rf_Read_Addr2, rf_Write_Addr, rf_Write_Data,
        input  rf_Dout1, rf_Dout2
    );

endinterface

// File: rtl/rf_phase_cnt.sv
// Free-running phase counter with access-slot detect.
// Latency: slot is combinational from the registered count.
// Backpressure: none; counts every cycle.
// Ports: clk, rst_n (async active-low); cnt_clk phase count; slot high in slot cycles.
module rf_phase_cnt
    import rf_arb_pkg::*;
#(
    parameter int SIZE_CNT = 2,
    parameter int CNT_CLK  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [SIZE_CNT:0] cnt_clk,
    output logic              slot
);

    localparam logic [SIZE_CNT:0] SLOT_LO = (SIZE_CNT+1)'(CNT_CLK);
    localparam logic [SIZE_CNT:0] SLOT_HI = (SIZE_CNT+1)'(CNT_CLK + SLOT_SPACING);
    localparam logic [SIZE_CNT:0] ONE     = (SIZE_CNT+1)'(1);

    logic [SIZE_CNT:0] cnt_q;
    logic [SIZE_CNT:0] cnt_d;

    // Wraps naturally from all-ones to zero
    always_comb begin
        cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_clk = cnt_q;
    assign slot    = (cnt_q == SLOT_LO) || (cnt_q == SLOT_HI);

endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter/sequencer for the 16x8 register file; owns cnt_clk.
// Latency: req to ack 3..6 cycles at default parameters (next slot after latch, +2).
// Backpressure: one command in flight; other requests wait until IDLE.
// Ports: clk, rst_n, cnt_clk out, bus (reg_file_arbiter_if.slave: a_*, b_*, rf_*).
// Config: define RF_ARB_RR_EN for round-robin on contention; otherwise A has priority.
module reg_file_arbiter
    import rf_arb_pkg::*;
#(
    parameter int SIZE_CNT = 2,
    parameter int CNT_CLK  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [SIZE_CNT:0]   cnt_clk,
    reg_file_arbiter_if.slave   bus
);

    logic slot;

    rf_phase_cnt #(
        .SIZE_CNT (SIZE_CNT),
        .CNT_CLK  (CNT_CLK)
    ) u_phase_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_clk (cnt_clk),
        .slot    (slot)
    );

    cmd_t   a_cmd, b_cmd;
    state_e state_q, state_d;
    gnt_e   gnt_q, gnt_d;
    cmd_t   cmd_q, cmd_d;
    logic   rf_wr_q, rf_wr_d;
    logic   a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [7:0] a_rd1_q, a_rd1_d, a_rd2_q, a_rd2_d;
    logic [7:0] b_rd1_q, b_rd1_d, b_rd2_q, b_rd2_d;
    logic   a_elig, b_elig, pick_b;

    assign a_cmd = {bus.a_wr, bus.a_raddr1, bus.a_raddr2, bus.a_waddr, bus.a_wdata};
    assign b_cmd = {bus.b_wr, bus.b_raddr1, bus.b_raddr2, bus.b_waddr, bus.b_wdata};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        rf_wr_d = rf_wr_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        a_rd1_d = a_rd1_q;
        a_rd2_d = a_rd2_q;
        b_rd1_d = b_rd1_q;
        b_rd2_d = b_rd2_q;

        // A requester still seeing its ack is finishing, not asking again
        a_elig = bus.a_req & ~a_ack_q;
        b_elig = bus.b_req & ~b_ack_q;
`ifdef RF_ARB_RR_EN
        // gnt_q doubles as the "last granted" pointer
        pick_b = b_elig & (~a_elig | (gnt_q == GNT_A));
`else
        pick_b = b_elig & ~a_elig;
`endif

        case (state_q)
            IDLE: begin
                rf_wr_d = 1'b0;
                if (a_elig || b_elig) begin
                    gnt_d   = pick_b ? GNT_B : GNT_A;
                    cmd_d   = pick_b ? b_cmd : a_cmd;
                    rf_wr_d = pick_b ? b_cmd.wr : a_cmd.wr;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // The register file acts on the edge closing the slot cycle
                if (slot) begin
                    rf_wr_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (gnt_q == GNT_A) begin
                    a_ack_d = 1'b1;
                    if (!cmd_q.wr) begin
                        a_rd1_d = bus.rf_Dout1;
                        a_rd2_d = bus.rf_Dout2;
                    end
                end else begin
                    b_ack_d = 1'b1;
                    if (!cmd_q.wr) begin
                        b_rd1_d = bus.rf_Dout1;
                        b_rd2_d = bus.rf_Dout2;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= GNT_B;
            cmd_q   <= '0;
            rf_wr_q <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_rd1_q <= '0;
            a_rd2_q <= '0;
            b_rd1_q <= '0;
            b_rd2_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            rf_wr_q <= rf_wr_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            a_rd1_q <= a_rd1_d;
            a_rd2_q <= a_rd2_d;
            b_rd1_q <= b_rd1_d;
            b_rd2_q <= b_rd2_d;
        end
    end

    assign bus.rf_WR         = rf_wr_q;
    assign bus.rf_Read_Addr1 = cmd_q.raddr1;
    assign bus.rf_Read_Addr2 = cmd_q.raddr2;
    assign bus.rf_Write_Addr = cmd_q.waddr;
    assign bus.rf_Write_Data = cmd_q.wdata;
    assign bus.a_ack         = a_ack_q;
    assign bus.a_rdata1      = a_rd1_q;
    assign bus.a_rdata2      = a_rd2_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.b_rdata1      = b_rd1_q;
    assign bus.b_rdata2      = b_rd2_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter with a transaction-level model.
// Latency: n/a.
// Backpressure: requesters hold req through their ack cycle.
module tb_reg_file_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cnt_clk;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       run_cmp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_arbiter_if bus();

    reg_file_arbiter #(.SIZE_CNT(2), .CNT_CLK(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_clk (cnt_clk),
        .bus     (bus)
    );

    // requester drive, index 0 = A, 1 = B
    logic       req [2];
    logic       wr  [2];
    logic [3:0] ra1 [2];
    logic [3:0] ra2 [2];
    logic [3:0] wa  [2];
    logic [7:0] wd  [2];
    logic       ack [2];
    logic [7:0] rd1 [2];
    logic [7:0] rd2 [2];

    assign bus.a_req = req[0]; assign bus.a_wr = wr[0];
    assign bus.a_raddr1 = ra1[0]; assign bus.a_raddr2 = ra2[0];
    assign bus.a_waddr = wa[0]; assign bus.a_wdata = wd[0];
    assign bus.b_req = req[1]; assign bus.b_wr = wr[1];
    assign bus.b_raddr1 = ra1[1]; assign bus.b_raddr2 = ra2[1];
    assign bus.b_waddr = wa[1]; assign bus.b_wdata = wd[1];
    assign ack[0] = bus.a_ack; assign rd1[0] = bus.a_rdata1; assign rd2[0] = bus.a_rdata2;
    assign ack[1] = bus.b_ack; assign rd1[1] = bus.b_rdata1; assign rd2[1] = bus.b_rdata2;

    // register file: writes on the edge closing a slot cycle, async reads
    logic [7:0] mem [16];
    logic       mem_init;
    always @(posedge clk) begin
        if (mem_init !== 1'b1) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem_init <= 1'b1;
        end else if (bus.rf_WR && (cnt_clk == 3'd1 || cnt_clk == 3'd5)) begin
            mem[bus.rf_Write_Addr] <= bus.rf_Write_Data;
        end
    end
    assign bus.rf_Dout1 = mem[bus.rf_Read_Addr1];
    assign bus.rf_Dout2 = mem[bus.rf_Read_Addr2];

    // ---------------- transaction-level reference model ----------------
    int         m_cyc, m_slot, m_gnt, m_pick;
    logic       m_busy, m_last, m_wr, m_init;
    logic [1:0] m_ack;
    logic [3:0] m_ra1, m_ra2, m_wa;
    logic [7:0] m_wd;
    logic [7:0] m_rd1 [2];
    logic [7:0] m_rd2 [2];
    logic [7:0] m_mem [16];

    // first cycle index after c whose phase is 1 or 5
    function automatic int next_slot(input int c);
        for (int s = c + 1; s <= c + 8; s++)
            if ((s % 8) == 1 || (s % 8) == 5) return s;
        return c + 1;
    endfunction

    function automatic int pick(input logic [1:0] el, input logic last);
        if (el == 2'b11) begin
`ifdef RF_ARB_RR_EN
            return last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (el[0]) return 0;
        if (el[1]) return 1;
        return -1;
    endfunction

    assign m_pick = pick({req[1] & ~m_ack[1], req[0] & ~m_ack[0]}, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_busy <= 1'b0; m_ack <= 2'b00; m_last <= 1'b1;
            m_slot <= 0; m_gnt <= 0; m_wr <= 1'b0;
            m_ra1 <= '0; m_ra2 <= '0; m_wa <= '0; m_wd <= '0;
            for (int i = 0; i < 2; i++) begin m_rd1[i] <= '0; m_rd2[i] <= '0; end
            if (m_init !== 1'b1) begin
                for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
                m_init <= 1'b1;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            m_ack <= 2'b00;
            if (m_busy) begin
                if (m_cyc == m_slot && m_wr) m_mem[m_wa] <= m_wd;
                if (m_cyc == m_slot + 1) begin
                    if (!m_wr) begin
                        m_rd1[m_gnt] <= m_mem[m_ra1];
                        m_rd2[m_gnt] <= m_mem[m_ra2];
                    end
                    m_ack[m_gnt] <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (m_pick >= 0) begin
                m_busy <= 1'b1;
                m_gnt  <= m_pick;
                m_last <= (m_pick == 1);
                m_slot <= next_slot(m_cyc);
                m_wr   <= wr[m_pick];
                m_ra1  <= ra1[m_pick];
                m_ra2  <= ra2[m_pick];
                m_wa   <= wa[m_pick];
                m_wd   <= wd[m_pick];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cnt_clk", 32'(cnt_clk), 32'(m_cyc % 8));
            check("a_ack", 32'(bus.a_ack), 32'(m_ack[0]));
            check("b_ack", 32'(bus.b_ack), 32'(m_ack[1]));
            check("a_rdata1", 32'(bus.a_rdata1), 32'(m_rd1[0]));
            check("a_rdata2", 32'(bus.a_rdata2), 32'(m_rd2[0]));
            check("b_rdata1", 32'(bus.b_rdata1), 32'(m_rd1[1]));
            check("b_rdata2", 32'(bus.b_rdata2), 32'(m_rd2[1]));
            check("rf_WR", 32'(bus.rf_WR), 32'(m_busy && m_wr && (m_cyc <= m_slot)));
            if (m_busy) begin
                check("rf_Write_Addr", 32'(bus.rf_Write_Addr), 32'(m_wa));
                check("rf_Write_Data", 32'(bus.rf_Write_Data), 32'(m_wd));
                check("rf_Read_Addr1", 32'(bus.rf_Read_Addr1), 32'(m_ra1));
                check("rf_Read_Addr2", 32'(bus.rf_Read_Addr2), 32'(m_ra2));
            end
        end
    end

    // Issue one command at posedge+1 and hold req through the ack cycle
    task automatic do_cmd(input int id, input logic w, input logic [3:0] r1, input logic [3:0] r2,
                          input logic [3:0] a, input logic [7:0] d,
                          output int lat, output int ack_cyc,
                          output logic [7:0] q1, output logic [7:0] q2, output logic [2:0] ack_ph);
        bit got;
        got = 0; lat = 0; ack_cyc = 0; q1 = '0; q2 = '0; ack_ph = '0;
        req[id] = 1'b1; wr[id] = w; ra1[id] = r1; ra2[id] = r2; wa[id] = a; wd[id] = d;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack[id]) begin
                got = 1; ack_cyc = cyc; q1 = rd1[id]; q2 = rd2[id]; ack_ph = cnt_clk;
            end else begin
                lat++;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    task automatic align(input logic [2:0] ph);
        for (int k = 0; k < 16 && cnt_clk != ph; k++) begin
            @(posedge clk); #1;
        end
    endtask

    int         lat_a, lat_b, ac_a, ac_b;
    logic [7:0] q1a, q2a, q1b, q2b;
    logic [2:0] pha, phb;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; ra1[i] = '0; ra2[i] = '0; wa[i] = '0; wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        run_cmp = 1'b1;
        check("rst_cnt", 32'(cnt_clk), 32'd0);
        check("rst_a_ack", 32'(bus.a_ack), 32'd0);
        check("rst_rf_WR", 32'(bus.rf_WR), 32'd0);
        check("rst_b_rdata1", 32'(bus.b_rdata1), 32'd0);
        check("rst_rf_wdata", 32'(bus.rf_Write_Data), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("cnt_seq", 32'(cnt_clk), 32'(k % 8));
        end
        @(posedge clk); #1;

        // write then read back
        do_cmd(0, 1'b1, 4'd0, 4'd0, 4'd3, 8'hA5, lat_a, ac_a, q1a, q2a, pha);
        check("wr_lat_3to6", 32'(lat_a >= 3 && lat_a <= 6), 32'd1);
        do_cmd(0, 1'b0, 4'd3, 4'd0, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
        check("rd_data1", 32'(q1a), 32'hA5);
        check("rd_data2", 32'(q2a), 32'h00);

        // latency extremes
        align(3'd0);
        do_cmd(0, 1'b0, 4'd1, 4'd2, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
        check("lat_from_ph0", 32'(lat_a), 32'd3);
        check("ack_ph_from0", 32'(pha), 32'd3);
        align(3'd1);
        do_cmd(0, 1'b0, 4'd1, 4'd2, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
        check("lat_from_ph1", 32'(lat_a), 32'd6);
        check("ack_ph_from1", 32'(pha), 32'd7);

        // contention after B was last: A wins, B is granted in A's ack cycle
        do_cmd(1, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, lat_b, ac_b, q1b, q2b, phb);
        fork
            do_cmd(0, 1'b0, 4'd3, 4'd1, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
            do_cmd(1, 1'b0, 4'd3, 4'd3, 4'd0, 8'h00, lat_b, ac_b, q1b, q2b, phb);
        join
        check("contend_a_first", 32'(ac_b - ac_a), 32'd4);
        check("contend_b_data", 32'(q1b), 32'hA5);

        // contention after A was last
        do_cmd(0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
        fork
            do_cmd(0, 1'b0, 4'd3, 4'd1, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
            do_cmd(1, 1'b0, 4'd3, 4'd3, 4'd0, 8'h00, lat_b, ac_b, q1b, q2b, phb);
        join
`ifdef RF_ARB_RR_EN
        check("rr_b_first", 32'(ac_a - ac_b), 32'd4);
`else
        check("fixed_a_first", 32'(ac_b - ac_a), 32'd4);
`endif

        // abort: reset while a write is armed
        do_cmd(0, 1'b1, 4'd0, 4'd0, 4'd5, 8'h11, lat_a, ac_a, q1a, q2a, pha);
        align(3'd2);
        req[0] = 1'b1; wr[0] = 1'b1; wa[0] = 4'd5; wd[0] = 8'h3C;
        @(posedge clk); #1;
        check("abort_armed_wr", 32'(bus.rf_WR), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rst_cnt", 32'(cnt_clk), 32'd0);
        check("abort_rst_wr", 32'(bus.rf_WR), 32'd0);
        check("abort_rst_waddr", 32'(bus.rf_Write_Addr), 32'd0);
        check("abort_rst_rdata", 32'(bus.a_rdata1), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_cnt_seq", 32'(cnt_clk), 32'(k % 8));
            check("abort_no_ack", 32'(bus.a_ack), 32'd0);
        end
        @(posedge clk); #1;
        do_cmd(0, 1'b0, 4'd5, 4'd5, 4'd0, 8'h00, lat_a, ac_a, q1a, q2a, pha);
        check("abort_reg5_kept", 32'(q1a), 32'h11);

        // randomized traffic from both requesters
        fork
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_cmd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 8'($urandom), lat_a, ac_a, q1a, q2a, pha);
            end
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_cmd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 8'($urandom), lat_b, ac_b, q1b, q2b, phb);
            end
        join

        repeat (4) @(negedge clk);
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
